// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the VGA pixel generator.
//   - H_START/V_START: counter values of the first visible pixel/line.
//   - H_VIS/V_VIS: visible area size.
//   - mode_e: pattern select encoding.
//   - BAR_RGB: colour-bar masks {R,G,B}, one bit per channel, index 0 = leftmost bar.
package vga_pkg;

  localparam int unsigned H_START = 160;
  localparam int unsigned V_START = 41;
  localparam int unsigned H_VIS   = 640;
  localparam int unsigned V_VIS   = 480;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_BOX     = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  localparam logic [7:0][2:0] BAR_RGB = {
    BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
    BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE
  };

endpackage

// File: rtl/vga_box_mover.sv
// vga_box_mover: per-frame position of the bouncing box.
//   clk_25   : pixel clock
//   reset_n  : synchronous active-low reset (box to (0,0), both directions +)
//   tick_i   : one-cycle frame tick; box advances one pixel per axis on it
//   box_x_o  : box left edge, 0..X_MAX
//   box_y_o  : box top edge, 0..Y_MAX
module vga_box_mover #(
  parameter int unsigned X_MAX = 608,
  parameter int unsigned Y_MAX = 448
) (
  input  logic       clk_25,
  input  logic       reset_n,
  input  logic       tick_i,
  output logic [9:0] box_x_o,
  output logic [9:0] box_y_o
);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = moving towards MAX

  // Returns {dir, pos} after one step; reversal also moves one pixel back
  // so the box never sits on the wall for two frames.
  function automatic logic [10:0] step_axis(input logic up, input logic [9:0] pos,
                                            input logic [9:0] max);
    if (up && pos == max)          return {1'b0, max - 10'd1};
    else if (!up && pos == 10'd0)  return {1'b1, 10'd1};
    else if (up)                   return {1'b1, pos + 10'd1};
    else                           return {1'b0, pos - 10'd1};
  endfunction

  always_comb begin
    {dir_x_d, x_d} = step_axis(dir_x_q, x_q, 10'(X_MAX));
    {dir_y_d, y_d} = step_axis(dir_y_q, y_q, 10'(Y_MAX));
  end

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else if (tick_i) begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  assign box_x_o = x_q;
  assign box_y_o = y_q;

endmodule

// File: rtl/vga_pixel_gen.sv
// vga_pixel_gen: renders test patterns behind the VGA timing generator.
//   clk_25, reset_n          : pixel clock, synchronous active-low reset
//   h_sync_in, v_sync_in     : syncs from the timing generator
//   h_count, v_count, bright : counters and vertical visible flag
//   mode                     : 0 bars, 1 checker, 2 box, 3 solid (latched per frame)
//   solid_color              : {R,G,B} for solid mode and box fill
//   vga_r/g/b                : pixel colour, 2 cycles after the inputs
//   h_sync_out, v_sync_out   : syncs delayed to line up with the colour
module vga_pixel_gen #(
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned H_START  = vga_pkg::H_START,
  parameter int unsigned V_START  = vga_pkg::V_START,
  parameter int unsigned H_VIS    = vga_pkg::H_VIS,
  parameter int unsigned V_VIS    = vga_pkg::V_VIS,
  parameter int unsigned BOX_SIZE = 32
) (
  input  logic                   clk_25,
  input  logic                   reset_n,
  input  logic                   h_sync_in,
  input  logic                   v_sync_in,
  input  logic [9:0]             h_count,
  input  logic [9:0]             v_count,
  input  logic                   bright,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_color,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   h_sync_out,
  output logic                   v_sync_out
);
  import vga_pkg::*;

  localparam int unsigned PIX_W = 3 * COLOR_W;
  localparam logic [10:0] H_END = 11'(H_START + H_VIS);

  logic             prev_vs_q;
  logic             frame_tick;
  mode_e            mode_q;
  logic [9:0]       box_x, box_y;

  logic             vis_d;
  logic [9:0]       x_d, y_d;
  logic             vld_p1_q;
  logic [9:0]       x_p1_q, y_p1_q;
  logic             hs_p1_q, vs_p1_q;

  logic [PIX_W-1:0] rgb_d;
  logic [PIX_W-1:0] rgb_p2_q;
  logic             hs_p2_q, vs_p2_q;

  function automatic logic [PIX_W-1:0] expand_mask(input logic [2:0] m);
    return {{COLOR_W{m[2]}}, {COLOR_W{m[1]}}, {COLOR_W{m[0]}}};
  endfunction

  // x/80 by range compares; x is always < 640 when it is used.
  function automatic logic [2:0] bar_index(input logic [9:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(i * 80)) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [PIX_W-1:0] pixel_color(
    input logic vld, input mode_e md, input logic [9:0] x, input logic [9:0] y,
    input logic [9:0] bx, input logic [9:0] by, input logic [PIX_W-1:0] solid);
    logic             in_box;
    logic [PIX_W-1:0] c;
    c = '0;
    // 11-bit upper bounds so bx+BOX_SIZE cannot wrap.
    in_box = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < ({1'b0, bx} + 11'(BOX_SIZE))) &&
             ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < ({1'b0, by} + 11'(BOX_SIZE)));
    if (vld) begin
      case (md)
        MODE_BARS:    c = expand_mask(BAR_RGB[bar_index(x)]);
        MODE_CHECKER: c = (x[5] ^ y[5]) ? '1 : '0;
        MODE_BOX:     c = in_box ? solid : '0;
        default:      c = solid;
      endcase
    end
    return c;
  endfunction

  assign frame_tick = prev_vs_q & ~v_sync_in;

  vga_box_mover #(
    .X_MAX (H_VIS - BOX_SIZE),
    .Y_MAX (V_VIS - BOX_SIZE)
  ) u_box (
    .clk_25  (clk_25),
    .reset_n (reset_n),
    .tick_i  (frame_tick),
    .box_x_o (box_x),
    .box_y_o (box_y)
  );

  always_comb begin
    vis_d = bright && ({1'b0, h_count} >= 11'(H_START)) && ({1'b0, h_count} < H_END);
    x_d   = h_count - 10'(H_START);
    y_d   = v_count - 10'(V_START);
    rgb_d = pixel_color(vld_p1_q, mode_q, x_p1_q, y_p1_q, box_x, box_y, solid_color);
  end

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      prev_vs_q <= 1'b1;
      mode_q    <= MODE_BARS;
      vld_p1_q  <= 1'b0;
      x_p1_q    <= '0;
      y_p1_q    <= '0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
      rgb_p2_q  <= '0;
      hs_p2_q   <= 1'b1;
      vs_p2_q   <= 1'b1;
    end else begin
      prev_vs_q <= v_sync_in;
      if (frame_tick) mode_q <= mode_e'(mode);
      // Stage 1: visibility, pixel coordinates and raw syncs
      vld_p1_q  <= vis_d;
      x_p1_q    <= x_d;
      y_p1_q    <= y_d;
      hs_p1_q   <= h_sync_in;
      vs_p1_q   <= v_sync_in;
      // Stage 2: rendered colour and aligned syncs
      rgb_p2_q  <= rgb_d;
      hs_p2_q   <= hs_p1_q;
      vs_p2_q   <= vs_p1_q;
    end
  end

  assign vga_r      = rgb_p2_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g      = rgb_p2_q[2*COLOR_W-1:COLOR_W];
  assign vga_b      = rgb_p2_q[COLOR_W-1:0];
  assign h_sync_out = hs_p2_q;
  assign v_sync_out = vs_p2_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
module tb_vga_pixel_gen;

  logic        clk_25 = 1'b0;
  logic        reset_n = 1'b0;
  logic        h_sync_in = 1'b1, v_sync_in = 1'b1, bright = 1'b0;
  logic [9:0]  h_count = '0, v_count = '0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] solid_color = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        h_sync_out, v_sync_out;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_vld1 = 1'b0, m_hs1 = 1'b1, m_vs1 = 1'b1, m_pvs = 1'b1;
  int          m_x1 = 0, m_y1 = 0, m_mode = 0;
  int          bx = 0, by = 0, dx = 1, dy = 1;
  logic [11:0] m_out = '0;
  logic        m_hso = 1'b1, m_vso = 1'b1;
  logic [11:0] bars_tab [8];

  always #20 clk_25 = ~clk_25;

  vga_pixel_gen dut (
    .clk_25      (clk_25),
    .reset_n     (reset_n),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .h_count     (h_count),
    .v_count     (v_count),
    .bright      (bright),
    .mode        (mode),
    .solid_color (solid_color),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_color(input int x, input int y);
    case (m_mode)
      0: return bars_tab[x / 80];
      1: return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2: return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? solid_color : 12'h000;
      default: return solid_color;
    endcase
  endfunction

  task automatic bounce(inout int pos, inout int dir, input int maxv);
    if (dir > 0 && pos == maxv)  begin dir = -1; pos = maxv - 1; end
    else if (dir < 0 && pos == 0) begin dir = 1; pos = 1; end
    else pos += dir;
  endtask

  task automatic model_edge();
    int  hc, vc;
    logic tick;
    hc = int'(h_count);
    vc = int'(v_count);
    if (!reset_n) begin
      m_out = '0; m_hso = 1'b1; m_vso = 1'b1;
      m_vld1 = 1'b0; m_x1 = 0; m_y1 = 0; m_hs1 = 1'b1; m_vs1 = 1'b1;
      m_mode = 0; bx = 0; by = 0; dx = 1; dy = 1; m_pvs = 1'b1;
    end else begin
      m_out  = m_vld1 ? ref_color(m_x1, m_y1) : 12'h000;
      m_hso  = m_hs1;
      m_vso  = m_vs1;
      m_vld1 = bright && hc >= 160 && hc < 800;
      m_x1   = (hc - 160) & 1023;
      m_y1   = (vc - 41) & 1023;
      m_hs1  = h_sync_in;
      m_vs1  = v_sync_in;
      tick   = m_pvs && !v_sync_in;
      m_pvs  = v_sync_in;
      if (tick) begin
        m_mode = int'(mode);
        bounce(bx, dx, 608);
        bounce(by, dy, 448);
      end
    end
  endtask

  task automatic cyc(input int hc, input int vc, input logic br, input logic hs, input logic vs);
    h_count   = 10'(hc);
    v_count   = 10'(vc);
    bright    = br;
    h_sync_in = hs;
    v_sync_in = vs;
    @(posedge clk_25);
    model_edge();
    #1;
    chk("pipe", {vga_r, vga_g, vga_b, h_sync_out, v_sync_out}, {m_out, m_hso, m_vso});
  endtask

  task automatic probe_raw(input string tag, input int hc, input int vc, input logic br,
                           input logic [11:0] exp);
    cyc(hc, vc, br, 1'b1, 1'b1);
    cyc(0, 0, 1'b0, 1'b1, 1'b1);
    chk(tag, {vga_r, vga_g, vga_b}, exp);
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic [11:0] exp);
    probe_raw(tag, x + 160, y + 41, 1'b1, exp);
  endtask

  task automatic tick();
    cyc(0, 0, 1'b0, 1'b1, 1'b0);
    cyc(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(0, 0, 1'b0, 1'b1, 1'b1);
    reset_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_hs, h;
    bars_tab = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // reset with a running generator
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(160 + i * 100, 100, 1'b1, 1'($urandom), 1'b1);
      chk("rst_out", {vga_r, vga_g, vga_b, h_sync_out, v_sync_out}, 32'h3);
    end
    reset_n = 1'b1;

    // h_sync delay
    prev_hs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      h = 1'($urandom);
      cyc(0, 0, 1'b0, h, 1'b1);
      if (i > 0) chk("hs_delay", h_sync_out, prev_hs);
      prev_hs = h;
    end

    // bars (mode_q = 0 from reset)
    probe("bar_x0",   0,   5, 12'hFFF);
    probe("bar_x79",  79,  5, 12'hFFF);
    probe("bar_x80",  80,  5, 12'hFF0);
    probe("bar_x559", 559, 5, 12'h00F);
    probe("bar_x560", 560, 5, 12'h000);
    probe("bar_x639", 639, 5, 12'h000);
    probe_raw("bar_h159", 159, 46, 1'b1, 12'h000);
    probe_raw("bar_h800", 800, 46, 1'b1, 12'h000);

    // checker
    mode = 2'd1;
    tick();
    probe("chk_0_0",   0,  0, 12'h000);
    probe("chk_32_0",  32, 0, 12'hFFF);
    probe("chk_32_32", 32, 32, 12'h000);

    // bouncing box
    do_reset();
    mode = 2'd2;
    solid_color = 12'hF00;
    tick();
    probe("box1_in",    1,  1,  12'hF00);
    probe("box1_out",   0,  0,  12'h000);
    probe("box1_far",   32, 32, 12'hF00);
    probe("box1_right", 33, 1,  12'h000);
    for (int i = 0; i < 607; i++) tick();
    probe("box608_in",  608, 288, 12'hF00);
    probe("box608_out", 607, 288, 12'h000);
    tick();
    probe("box609_in",  607, 287, 12'hF00);
    probe("box609_r",   638, 287, 12'hF00);
    probe("box609_out", 639, 287, 12'h000);

    // mode change waits for the frame tick
    mode = 2'd0;
    tick();
    mode = 2'd3;
    solid_color = 12'h5A3;
    probe("switch_mid", 80, 10, 12'hFF0);
    tick();
    probe("switch_next", 80, 10, 12'h5A3);
    probe_raw("dark_solid", 300, 100, 1'b0, 12'h000);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      mode = 2'($urandom);
      if ($urandom_range(0, 15) == 0) solid_color = 12'($urandom);
      cyc($urandom_range(140, 820), $urandom_range(0, 540),
          ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) != 0));
    end
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
